// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences mult/div requests to the external multiplier and
// divider, captures their 64-bit result into the architectural HI/LO
// registers, services mthi/mtlo and stalls the control unit while busy.
// Optional WAIT watchdog enabled by defining HILO_TIMEOUT_EN.
module hilo_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        op_start,
  input  logic        op_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        MultIn,
  input  logic        MultOut,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        DivIn,
  input  logic        DivOut,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DZERO} state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;
  logic        unit_done;

`ifdef HILO_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  assign timeout = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  assign unit_done = sel_q ? DivOut : MultOut;

  assign A        = a_q;
  assign B        = b_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != IDLE);
  assign MultIn   = (state_q == ISSUE) && !sel_q;
  assign DivIn    = (state_q == ISSUE) && sel_q;
  assign done     = done_q;
  assign div_zero = dz_q;

  // Next-state, operand/result capture and completion pulses.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
`ifdef HILO_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Direct writes land first; a result accepted here overwrites later.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (op_start) begin
          a_d     = op_a;
          b_d     = op_b;
          sel_d   = op_sel;
          state_d = (op_sel && (op_b == '0)) ? DZERO : ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef HILO_TIMEOUT_EN
        cnt_d   = CW'(TIMEOUT);
`endif
      end
      WAIT: begin
        // Done on the final count takes priority over the watchdog.
        if (unit_done) begin
          hi_d    = sel_q ? div_hi : mult_hi;
          lo_d    = sel_q ? div_lo : mult_lo;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef HILO_TIMEOUT_EN
        else if (cnt_q <= CW'(1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
`endif
      end
      DZERO: begin
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef HILO_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef HILO_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: the bench plays the control unit and
// both arithmetic units, keeps a transaction-level timeline of what every
// output must be in each cycle, and compares on every falling edge.
`timescale 1ns/1ps
module tb_hilo_ctrl;

  localparam int unsigned TO = 40;
`ifdef HILO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic        op_start, op_sel;
  logic [31:0] op_a, op_b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic [31:0] A, B;
  logic        MultIn, MultOut;
  logic [31:0] mult_hi, mult_lo;
  logic        DivIn, DivOut;
  logic [31:0] div_hi, div_lo;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, timeout;

  always #5 clk = ~clk;

  hilo_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset), .op_start(op_start), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .A(A), .B(B), .MultIn(MultIn), .MultOut(MultOut),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .DivIn(DivIn), .DivOut(DivOut),
    .div_hi(div_hi), .div_lo(div_lo), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  // Architectural model state and per-cycle expectations.
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [31:0] e_hi, e_lo, e_a, e_b;
  logic        e_busy, e_done, e_dz, e_to, e_min, e_din;
  bit          chk_en = 1'b0;
  bit          hold_other = 1'b0;
  bit          busy_wr = 1'b0;
  int unsigned n_cmp = 0, n_bad = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("hi", hi, e_hi);
      cmp("lo", lo, e_lo);
      cmp("A", A, e_a);
      cmp("B", B, e_b);
      cmp("busy", busy, e_busy);
      cmp("done", done, e_done);
      cmp("div_zero", div_zero, e_dz);
      cmp("timeout", timeout, e_to);
      cmp("MultIn", MultIn, e_min);
      cmp("DivIn", DivIn, e_din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit b_x, input bit d_x, input bit z_x,
                         input bit t_x, input bit mi_x, input bit di_x);
    e_hi = m_hi; e_lo = m_lo; e_a = m_a; e_b = m_b;
    e_busy = b_x; e_done = d_x; e_dz = z_x; e_to = t_x; e_min = mi_x; e_din = di_x;
  endtask

  // Reference arithmetic of the external units: signed product, or
  // remainder/quotient packed as {hi, lo}.
  function automatic logic [63:0] unit_result(input bit sel, input logic [31:0] a,
                                              input logic [31:0] b);
    longint sa, sb;
    if (sel) return (b == 0) ? 64'd0 : {a % b, a / b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  // mode 0: selected unit noise, 1: selected done low, 2: selected done high with result.
  task automatic drive_units(input bit sel, input int unsigned mode);
    logic [63:0] r;
    mult_hi = $urandom; mult_lo = $urandom;
    div_hi  = $urandom; div_lo  = $urandom;
    MultOut = (hold_other && sel)  ? 1'b1 : 1'($urandom_range(0, 1));
    DivOut  = (hold_other && !sel) ? 1'b1 : 1'($urandom_range(0, 1));
    if (mode != 0) begin
      if (sel) DivOut = (mode == 2); else MultOut = (mode == 2);
      if (mode == 2) begin
        r = unit_result(sel, A, B);
        if (sel) begin div_hi = r[63:32]; div_lo = r[31:0]; end
        else begin mult_hi = r[63:32]; mult_lo = r[31:0]; end
      end
    end
  endtask

  task automatic busy_writes();
    mthi  = busy_wr ? 1'b1 : 1'($urandom_range(0, 1));
    mtlo  = busy_wr ? 1'b1 : 1'($urandom_range(0, 1));
    wdata = $urandom;
  endtask

  task automatic idle_cycle(input bit wh, input bit wl, input logic [31:0] wd);
    op_start = 1'b0; mthi = wh; mtlo = wl; wdata = wd;
    drive_units(1'($urandom_range(0, 1)), 0);
    tick();
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
    set_exp(0, 0, 0, 0, 0, 0);
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  // One request from acceptance to its completion cycle (left in that cycle).
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned lat, input bit wh, input bit wl,
                        input logic [31:0] wd);
    int unsigned n_wait;
    logic [63:0] r;
    op_start = 1'b1; op_sel = sel; op_a = a; op_b = b;
    mthi = wh; mtlo = wl; wdata = wd;
    drive_units(sel, 0);
    tick();
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
    m_a = a; m_b = b;
    op_start = 1'b0; op_a = $urandom; op_b = $urandom; op_sel = 1'($urandom_range(0, 1));
    if (sel && b == 0) begin
      set_exp(1, 0, 0, 0, 0, 0);
      drive_units(sel, 0); busy_writes();
      tick();
      set_exp(0, 1, 1, 0, 0, 0);
    end else begin
      set_exp(1, 0, 0, 0, !sel, sel);
      drive_units(sel, 0); busy_writes();
      tick();
      n_wait = (TO_EN && lat > TO) ? TO : lat;
      for (int unsigned k = 1; k <= n_wait; k++) begin
        set_exp(1, 0, 0, 0, 0, 0);
        drive_units(sel, (k == lat) ? 2 : 1); busy_writes();
        tick();
      end
      if (n_wait == lat) begin
        r = unit_result(sel, a, b);
        m_hi = r[63:32]; m_lo = r[31:0];
        set_exp(0, 1, 0, 0, 0, 0);
      end else begin
        set_exp(0, 0, 0, 1, 0, 0);
      end
    end
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  task automatic reset_mid_wait();
    op_start = 1'b1; op_sel = 1'b0; op_a = $urandom; op_b = $urandom;
    mthi = 1'b0; mtlo = 1'b0;
    drive_units(0, 0);
    tick();
    m_a = op_a; m_b = op_b; op_start = 1'b0;
    set_exp(1, 0, 0, 0, 1, 0);
    drive_units(0, 0); busy_writes();
    tick();
    for (int unsigned k = 0; k < 4; k++) begin
      set_exp(1, 0, 0, 0, 0, 0);
      drive_units(0, 1); busy_writes();
      Reset = (k == 3);
      tick();
    end
    m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
    set_exp(0, 0, 0, 0, 0, 0);
    Reset = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    drive_units(0, 2);
    tick();
    set_exp(0, 0, 0, 0, 0, 0);
    cmp("rst_mid_busy", busy, 1'b0);
    cmp("rst_mid_hilo", {hi, lo}, 64'h0);
    cmp("rst_mid_done", done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int unsigned kind;
    Reset = 1'b1; op_start = 1'b0; op_sel = 1'b0; op_a = '0; op_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    MultOut = 1'b0; DivOut = 1'b0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
    tick();
    set_exp(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    tick();
    set_exp(0, 0, 0, 0, 0, 0);
    cmp("reset_hilo", {hi, lo}, 64'h0);
    Reset = 1'b0;
    idle_cycle(0, 0, '0);

    // mult 7 x -3, 33-cycle unit
    run_op(0, 32'd7, 32'hFFFF_FFFD, 33, 0, 0, '0);
    cmp("mul_7x-3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // div 100 / 7 with a stale multiplier done held high
    hold_other = 1'b1;
    run_op(1, 32'd100, 32'd7, 12, 0, 0, '0);
    hold_other = 1'b0;
    cmp("div_100/7", {hi, lo}, {32'd2, 32'd14});

    // divide by zero keeps HI/LO
    run_op(1, 32'd5, 32'd0, 1, 0, 0, '0);
    cmp("div_zero_hilo", {hi, lo}, {32'd2, 32'd14});

    // mthi in IDLE, then both writes dropped throughout a busy op
    idle_cycle(1, 0, 32'hDEAD_BEEF);
    cmp("mthi", hi, 32'hDEAD_BEEF);
    busy_wr = 1'b1;
    run_op(1, 32'd9, 32'd0, 1, 0, 0, '0);
    busy_wr = 1'b0;
    cmp("mtlo_busy_drop", {hi, lo}, {32'hDEAD_BEEF, 32'd14});

    // write with acceptance: persists on div-zero, overwritten by a result
    run_op(1, 32'd3, 32'd0, 1, 1, 1, 32'h1234_5678);
    cmp("wr_with_dz", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
    run_op(0, 32'd6, 32'd5, 1, 1, 1, 32'hAAAA_5555);
    cmp("wr_then_res", {hi, lo}, 64'd30);

    reset_mid_wait();

    // watchdog boundaries
    run_op(0, 32'd11, 32'd13, TO, 0, 0, '0);
    cmp("done_on_last_count", done, 1'b1);
`ifdef HILO_TIMEOUT_EN
    run_op(0, 32'd2, 32'd3, TO + 1, 0, 0, '0);
    cmp("timeout_pulse", timeout, 1'b1);
    run_op(1, 32'd50, 32'd4, 100000, 0, 0, '0);
    cmp("timeout_hilo", {hi, lo}, 64'd143);
`endif

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      hold_other = ($urandom_range(0, 3) == 0);
      if (kind < 2)
        idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      else if (kind < 5)
        run_op(0, ra, ($urandom_range(0, 7) == 0) ? 32'd0 : rb, $urandom_range(1, 45),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      else if (kind < 8)
        run_op(1, ra, (rb == 0) ? 32'd1 : rb, $urandom_range(1, 45),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      else
        run_op(1, ra, 32'd0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
    hold_other = 1'b0;
    idle_cycle(0, 0, '0);
    idle_cycle(0, 0, '0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencing and result-register stage downstream of the Booth multiplier and the divider. Accepts mult/div requests from the control unit, registers operands, issues a one-cycle start pulse to the selected unit, waits for its done flag, and captures the 64-bit result into the architectural HI/LO registers read by mfhi/mflo. Also services mthi/mtlo writes and provides a busy stall to the control unit.

## Interface
- TIMEOUT, 40: max WAIT cycles before abort (only with HILO_TIMEOUT_EN)
- clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- op_start  in  1  request; accepted only in IDLE
- op_sel  in  1  0 = mult, 1 = div
- op_a, op_b  in  32  operands, sampled at acceptance
- mthi, mtlo  in  1  write wdata to HI / LO
- wdata  in  32  mthi/mtlo data
- A, B  out  32  registered operands to multiplier and divider
- MultIn  out  1  multiplier start pulse
- MultOut  in  1  multiplier done (level; stays high until next MultIn)
- mult_hi, mult_lo  in  32  multiplier result
- DivIn  out  1  divider start pulse
- DivOut  in  1  divider done (same level behaviour as MultOut)
- div_hi, div_lo  in  32  remainder / quotient
- hi, lo  out  32  architectural HI / LO
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse, divide by zero
- timeout  out  1  one-cycle pulse, watchdog abort

## Operation
- States: IDLE, ISSUE, WAIT, DZERO.
- IDLE: op_start=1 -> latch op_a/op_b into A/B, latch op_sel; if op_sel=1 and op_b=0 -> DZERO, else -> ISSUE.
- ISSUE: MultIn (op_sel=0) or DivIn (op_sel=1) high for exactly this cycle -> WAIT.
- WAIT: done input (MultOut or DivOut per latched op_sel) ignored in ISSUE, sampled from the first WAIT cycle; when high -> hi/lo <= unit result on that edge, done pulsed next cycle, -> IDLE. Unselected unit's done ignored.
- DZERO: hi/lo unchanged; done and div_zero pulse next cycle; -> IDLE. Divider never started.
- mthi/mtlo honoured only in IDLE; dropped in any other state (control must stall on busy). Both high -> both written.
- mthi/mtlo and op_start same IDLE cycle: write performed; result later overwrites.
- A/B held stable from acceptance until next acceptance.
- Reset (any state, incl. mid-WAIT): state IDLE; hi, lo, A, B = 0; MultIn, DivIn, busy, done, div_zero, timeout = 0. In-flight result discarded.

## Timing
- op_start accepted on edge T; MultIn/DivIn high during cycle T..T+1; WAIT from edge T+1.
- Done input seen high at edge E: hi/lo updated at E; done=1 and busy=0 during cycle after E.
- Total latency = unit latency + 2 cycles; DZERO path: done at cycle after acceptance edge + 1.
- New op_start accepted in the same cycle done is high (state IDLE).
- busy rises the cycle after acceptance.

## Configuration
- HILO_TIMEOUT_EN defined: counter loaded with TIMEOUT on entering WAIT, decremented each WAIT cycle; reaching 0 without done -> IDLE, timeout pulse, no done, hi/lo unchanged. Done arriving on the final count wins over timeout.
- Undefined: WAIT lasts indefinitely; timeout tied 0; TIMEOUT unused.

## Test plan
- mult 7 x -3 with 33-cycle multiplier model -> single MultIn pulse, {hi,lo}=0xFFFFFFFF_FFFFFFEB, one done pulse, DivIn never high.
- div 100 / 7 -> lo=14, hi=2; stale MultOut=1 held throughout ignored.
- div 5 / 0 -> DivIn never asserted, done+div_zero pulse, hi/lo keep prior values.
- mthi 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle; mtlo during WAIT -> lo unchanged.
- Reset asserted mid-WAIT then MultOut rises -> hi=lo=0, busy=0, no done.
- HILO_TIMEOUT_EN, TIMEOUT=40, unit never finishes -> timeout pulse 40 cycles after entering WAIT, busy drops, hi/lo unchanged.
